// File: rtl/pinball_pkg.sv
// Shared pinball definitions: dispenser/game state codes, magazine size and
// 100 MHz timing constants used as defaults by the dispenser.
package pinball_pkg;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_OPEN,
    DS_CLOSE,
    DS_WAIT_SEEN
  } disp_state_e;

  typedef enum logic [2:0] {
    GS_RESET,
    GS_WAIT,
    GS_START,
    GS_GET,
    GS_OVER
  } game_state_e;

  localparam int BALLS_MAX_DEF     = 8;
  localparam int PWM_PERIOD_CLK    = 2_000_000;
  localparam int PULSE_CLOSED_CLK  = 100_000;
  localparam int PULSE_OPEN_CLK    = 200_000;
  localparam int OPEN_CYCLES_CLK   = 50_000_000;
  localparam int CLOSE_CYCLES_CLK  = 25_000_000;
  localparam int SENSE_TIMEOUT_CLK = 200_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo pulse generator: free-running frame counter, width latched only at the
// frame boundary so a change never produces a truncated pulse; registered output.
module servo_pwm_gen #(
  parameter int PWM_PERIOD  = 2_000_000,
  parameter int PULSE_RESET = 100_000,
  parameter int W           = $clog2(PWM_PERIOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] width_req,
  output logic         pwm
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] width_q, width_d;
  logic         pwm_q, pwm_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    width_d = width_q;
    if (cnt_q == W'(PWM_PERIOD - 1)) begin
      cnt_d   = '0;
      width_d = width_req;
    end
    pwm_d = (cnt_q < width_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      width_q <= W'(PULSE_RESET);
      pwm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      width_q <= width_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/ball_dispenser.sv
// Magazine ball dispenser: opens the servo gate for one ball per request, then
// waits for the lane sensors to confirm. Define DISPENSER_RETRY_EN to allow one
// re-open after the first sense timeout before flagging a jam.
module ball_dispenser
  import pinball_pkg::*;
#(
  parameter int PWM_PERIOD    = PWM_PERIOD_CLK,
  parameter int PULSE_CLOSED  = PULSE_CLOSED_CLK,
  parameter int PULSE_OPEN    = PULSE_OPEN_CLK,
  parameter int OPEN_CYCLES   = OPEN_CYCLES_CLK,
  parameter int CLOSE_CYCLES  = CLOSE_CYCLES_CLK,
  parameter int SENSE_TIMEOUT = SENSE_TIMEOUT_CLK,
  parameter int BALLS_MAX     = BALLS_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       refill,
  input  logic       ball_seen,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       empty,
  output logic [3:0] balls_left,
  output logic       servo_pwm
);

  localparam int PW = $clog2(PWM_PERIOD);
  localparam int TW = $clog2(max3(OPEN_CYCLES, CLOSE_CYCLES, SENSE_TIMEOUT));

  disp_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    balls_q, balls_d;
  logic          seen_q, seen_d;
  logic          fault_q, fault_d;
  logic          done_q, done_d;
  logic          retry_q, retry_d;
  logic [PW-1:0] width_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DS_IDLE;
      timer_q <= '0;
      balls_q <= 4'(BALLS_MAX);
      seen_q  <= 1'b0;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      balls_q <= balls_d;
      seen_q  <= seen_d;
      fault_q <= fault_d;
      done_q  <= done_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    balls_d = balls_q;
    seen_d  = seen_q;
    fault_d = fault_q;
    done_d  = 1'b0;
    retry_d = retry_q;
    // An early ball is remembered so WAIT_SEEN can finish on its first cycle.
    if (ball_seen && (state_q != DS_IDLE)) seen_d = 1'b1;
    unique case (state_q)
      DS_IDLE: begin
        timer_d = '0;
        if (refill) balls_d = 4'(BALLS_MAX);
        if (req && (balls_d != 4'd0)) begin
          state_d = DS_OPEN;
          fault_d = 1'b0;
          seen_d  = 1'b0;
          retry_d = 1'b0;
        end
      end
      DS_OPEN: begin
        if (timer_q == TW'(OPEN_CYCLES - 1)) begin
          state_d = DS_CLOSE;
          timer_d = '0;
          if (!retry_q) balls_d = balls_q - 1'b1;
        end
      end
      DS_CLOSE: begin
        if (timer_q == TW'(CLOSE_CYCLES - 1)) begin
          state_d = DS_WAIT_SEEN;
          timer_d = '0;
        end
      end
      DS_WAIT_SEEN: begin
        if (seen_q || ball_seen) begin
          state_d = DS_IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end else if (timer_q == TW'(SENSE_TIMEOUT - 1)) begin
`ifdef DISPENSER_RETRY_EN
          if (!retry_q) begin
            state_d = DS_OPEN;
            timer_d = '0;
            retry_d = 1'b1;
          end else begin
            state_d = DS_IDLE;
            timer_d = '0;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
`else
          state_d = DS_IDLE;
          timer_d = '0;
          done_d  = 1'b1;
          fault_d = 1'b1;
`endif
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != DS_IDLE);
    empty     = (balls_q == 4'd0);
    width_req = (state_q == DS_OPEN) ? PW'(PULSE_OPEN) : PW'(PULSE_CLOSED);
  end

  assign done       = done_q;
  assign fault      = fault_q;
  assign balls_left = balls_q;

  servo_pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD),
    .PULSE_RESET(PULSE_CLOSED),
    .W          (PW)
  ) u_pwm (
    .clk      (clk),
    .reset    (reset),
    .width_req(width_req),
    .pwm      (servo_pwm)
  );

endmodule

// File: tb/tb_ball_dispenser.sv
// Directed bench for ball_dispenser with shortened timing; sample index s counts
// falling edges after the rising edge that accepted the request (s=0).
module tb_ball_dispenser;

  localparam int PWM_PERIOD    = 20;
  localparam int PULSE_CLOSED  = 2;
  localparam int PULSE_OPEN    = 4;
  localparam int OPEN_CYCLES   = 40;
  localparam int CLOSE_CYCLES  = 20;
  localparam int SENSE_TIMEOUT = 50;
  localparam int BALLS_MAX     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       refill = 1'b0;
  logic       ball_seen = 1'b0;
  logic       busy, done, fault, empty, servo_pwm;
  logic [3:0] balls_left;

  int total = 0;
  int bad = 0;
  int done_cnt, done_at, run, max_run, high_cnt;

  always #5 clk = ~clk;

  ball_dispenser #(
    .PWM_PERIOD   (PWM_PERIOD),
    .PULSE_CLOSED (PULSE_CLOSED),
    .PULSE_OPEN   (PULSE_OPEN),
    .OPEN_CYCLES  (OPEN_CYCLES),
    .CLOSE_CYCLES (CLOSE_CYCLES),
    .SENSE_TIMEOUT(SENSE_TIMEOUT),
    .BALLS_MAX    (BALLS_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .refill    (refill),
    .ball_seen (ball_seen),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .empty     (empty),
    .balls_left(balls_left),
    .servo_pwm (servo_pwm)
  );

  task automatic clear_stats();
    done_cnt = 0; done_at = -1; run = 0; max_run = 0; high_cnt = 0;
  endtask

  task automatic step(input int s);
    @(negedge clk);
    if (servo_pwm) begin
      run++; high_cnt++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (done) begin
      done_cnt++;
      done_at = s;
    end
  endtask

  task automatic kick(input bit with_refill);
    req = 1'b1;
    refill = with_refill;
    @(negedge clk);
    req = 1'b0;
    refill = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (balls_left !== 4'd8) begin bad++; $display("FAIL reset_balls got=%0d want=8", balls_left); end
    total++; if (servo_pwm !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || empty !== 1'b0) begin
      bad++; $display("FAIL reset_flags pwm=%0b done=%0b fault=%0b empty=%0b want all 0", servo_pwm, done, fault, empty);
    end
    reset = 1'b0;
    clear_stats();
    for (int s = 1; s <= 60; s++) step(s);
    total++; if (high_cnt != 6) begin bad++; $display("FAIL idle_pwm_high got=%0d want=6", high_cnt); end
    total++; if (max_run != 2) begin bad++; $display("FAIL idle_pwm_width got=%0d want=2", max_run); end
    total++; if (done_cnt != 0 || busy !== 1'b0) begin bad++; $display("FAIL idle_quiet done_cnt=%0d busy=%0b want 0/0", done_cnt, busy); end
    $display("txn reset+idle: pwm_high=%0d width=%0d balls=%0d", high_cnt, max_run, balls_left);
  endtask

  task automatic test_dispense_late_ball();
    kick(1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL late_busy_start got=%0b want=1", busy); end
    for (int s = 1; s <= 70; s++) begin
      step(s);
      if (s == 39) begin
        total++; if (balls_left !== 4'd8) begin bad++; $display("FAIL late_balls_in_open got=%0d want=8", balls_left); end
      end
      if (s == 40) begin
        total++; if (balls_left !== 4'd7) begin bad++; $display("FAIL late_balls_after_open got=%0d want=7", balls_left); end
      end
      ball_seen = (s == 65);
    end
    ball_seen = 1'b0;
    total++; if (done_cnt != 1 || done_at != 66) begin bad++; $display("FAIL late_done cnt=%0d at=%0d want 1 at 66", done_cnt, done_at); end
    total++; if (max_run != 4) begin bad++; $display("FAIL late_open_width got=%0d want=4", max_run); end
    total++; if (fault !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL late_end fault=%0b busy=%0b want 0/0", fault, busy); end
    $display("txn dispense late ball: done_at=%0d balls=%0d fault=%0b", done_at, balls_left, fault);
  endtask

  task automatic test_early_ball(input logic [3:0] balls_exp, input bit with_refill);
    kick(with_refill);
    total++; if (fault !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL early_start fault=%0b busy=%0b want 0/1", fault, busy); end
    for (int s = 1; s <= 65; s++) begin
      step(s);
      ball_seen = (s == 10);
    end
    ball_seen = 1'b0;
    total++; if (done_cnt != 1 || done_at != 61) begin bad++; $display("FAIL early_done cnt=%0d at=%0d want 1 at 61", done_cnt, done_at); end
    total++; if (balls_left !== balls_exp || fault !== 1'b0) begin
      bad++; $display("FAIL early_end balls=%0d fault=%0b want %0d/0", balls_left, fault, balls_exp);
    end
    $display("txn dispense early ball: done_at=%0d balls=%0d", done_at, balls_left);
  endtask

  task automatic test_timeout();
`ifdef DISPENSER_RETRY_EN
    localparam int T_END = 220;
`else
    localparam int T_END = 110;
`endif
    kick(1'b0);
    for (int s = 1; s <= T_END + 40; s++) begin
      step(s);
      if (s == T_END - 1) begin
        total++; if (fault !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL to_before fault=%0b busy=%0b want 0/1", fault, busy); end
      end
      if (s == T_END) begin
        total++; if (fault !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL to_expire fault=%0b done=%0b want 1/1", fault, done); end
      end
`ifdef DISPENSER_RETRY_EN
      if (s == 110) max_run = 0;
      if (s == 120) begin
        total++; if (busy !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL retry_busy busy=%0b fault=%0b want 1/0", busy, fault); end
      end
      if (s == 170) begin
        total++; if (max_run != 4) begin bad++; $display("FAIL retry_reopen width=%0d want=4", max_run); end
      end
`else
      if (s == 110) max_run = 0;
`endif
    end
`ifndef DISPENSER_RETRY_EN
    total++; if (max_run != 2) begin bad++; $display("FAIL to_closed_after width=%0d want=2", max_run); end
`endif
    total++; if (done_cnt != 1 || balls_left !== 4'd5) begin bad++; $display("FAIL to_end done_cnt=%0d balls=%0d want 1/5", done_cnt, balls_left); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0b want=1", fault); end
    $display("txn timeout: done_at=%0d fault=%0b balls=%0d", done_at, fault, balls_left);
  endtask

  task automatic test_empty_and_refill();
    test_early_ball(4'd4, 1'b0);
    test_early_ball(4'd3, 1'b0);
    test_early_ball(4'd2, 1'b0);
    test_early_ball(4'd1, 1'b0);
    test_early_ball(4'd0, 1'b0);
    total++; if (empty !== 1'b1 || balls_left !== 4'd0) begin bad++; $display("FAIL empty_flag empty=%0b balls=%0d want 1/0", empty, balls_left); end
    kick(1'b0);
    for (int s = 1; s <= 10; s++) begin
      step(s);
      if (busy !== 1'b0) done_cnt++;
    end
    total++; if (done_cnt != 0 || balls_left !== 4'd0) begin bad++; $display("FAIL empty_req_ignored busy/done=%0d balls=%0d want 0/0", done_cnt, balls_left); end
    $display("txn req while empty: ignored, balls=%0d", balls_left);
    kick(1'b1);
    total++; if (busy !== 1'b1 || balls_left !== 4'd8 || empty !== 1'b0) begin
      bad++; $display("FAIL refill_req busy=%0b balls=%0d empty=%0b want 1/8/0", busy, balls_left, empty);
    end
    for (int s = 1; s <= 65; s++) begin
      step(s);
      ball_seen = (s == 10);
    end
    ball_seen = 1'b0;
    total++; if (balls_left !== 4'd7 || done_cnt != 1) begin bad++; $display("FAIL refill_dispense balls=%0d done_cnt=%0d want 7/1", balls_left, done_cnt); end
    $display("txn refill+req: balls=%0d done_at=%0d", balls_left, done_at);
  endtask

  task automatic test_reset_mid_open();
    kick(1'b0);
    for (int s = 1; s <= 10; s++) step(s);
    reset = 1'b1;
    step(11);
    reset = 1'b0;
    total++; if (busy !== 1'b0 || balls_left !== 4'd8) begin bad++; $display("FAIL midreset_state busy=%0b balls=%0d want 0/8", busy, balls_left); end
    total++; if (servo_pwm !== 1'b0 || fault !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midreset_outs pwm=%0b fault=%0b done=%0b want 0/0/0", servo_pwm, fault, done);
    end
    clear_stats();
    for (int s = 12; s <= 71; s++) step(s);
    total++; if (high_cnt != 6 || max_run != 2) begin bad++; $display("FAIL midreset_pwm highs=%0d width=%0d want 6/2", high_cnt, max_run); end
    total++; if (busy !== 1'b0 || done_cnt != 0) begin bad++; $display("FAIL midreset_idle busy=%0b done_cnt=%0d want 0/0", busy, done_cnt); end
    $display("txn reset mid-open: balls=%0d width=%0d", balls_left, max_run);
  endtask

  initial begin
    test_reset();
    test_dispense_late_ball();
    test_early_ball(4'd6, 1'b0);
    test_timeout();
    test_empty_and_refill();
    test_reset_mid_open();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
